// File: rtl/inst_queue.sv
// Decoupling instruction queue between IF1 and decode: splits 1/2-instruction fetch packets into entries.
// Optional same-cycle bypass of an empty queue is enabled with INST_QUEUE_BYPASS_EN.
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module inst_queue #(
  parameter int DEPTH        = 8,
  parameter int LOG_DEPTH    = 3,
  parameter int SPACE_MARGIN = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pc_next,
  input  logic        in_taken,
  input  logic [31:0] in_inst0,
  input  logic [31:0] in_inst1,
  input  logic [1:0]  in_excp_flag,
  input  logic [6:0]  in_exception,
  input  logic [31:0] in_badv,
  output logic        space_ok,
  output logic        nearly_full,
  output logic [1:0]  out_valid,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  output logic [31:0] out_pc_next0,
  output logic [31:0] out_pc_next1,
  output logic [1:0]  out_taken,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [1:0]  out_excp,
  output logic [6:0]  out_exception0,
  output logic [6:0]  out_exception1,
  output logic [31:0] out_badv0,
  output logic [31:0] out_badv1,
  input  logic [1:0]  pop_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        taken;
    logic [31:0] inst;
    logic        excp;
    logic [6:0]  exception;
    logic [31:0] badv;
  } entry_t;

  typedef logic [LOG_DEPTH-1:0] ptr_t;
  localparam int CW = LOG_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(SPACE_MARGIN);
  localparam logic [CW-1:0] TWO_C    = CW'(2);
  localparam ptr_t          ONE_P    = ptr_t'(1);

  ptr_t          head, tail;
  logic [CW-1:0] count, free, avail;
  entry_t        mem [DEPTH];
  entry_t        ent [2];
  entry_t        slot [2];
  logic          push, byp;
  logic [1:0]    push_n, wr_skip, wr_n, st_pop, valid;

  assign free        = DEPTH_C - count;
  assign in_ready    = free >= TWO_C;
  assign space_ok    = free >= MARGIN_C;
  assign nearly_full = (free >= TWO_C) && (free < MARGIN_C);
  assign push        = in_valid && in_ready;
  assign push_n      = in_pc[2] ? 2'd1 : 2'd2;

  // Packet split: the last entry of the packet carries the prediction.
  always_comb begin
    ent[0].pc        = in_pc;
    ent[0].pc_next   = in_pc[2] ? in_pc_next : in_pc + 32'd4;
    ent[0].taken     = in_pc[2] ? in_taken : 1'b0;
    ent[0].inst      = in_inst0;
    ent[0].excp      = in_excp_flag[0];
    ent[0].exception = in_exception;
    ent[0].badv      = in_badv;
    ent[1].pc        = in_pc + 32'd4;
    ent[1].pc_next   = in_pc_next;
    ent[1].taken     = in_taken;
    ent[1].inst      = in_inst1;
    ent[1].excp      = in_excp_flag[1];
    ent[1].exception = in_exception;
    ent[1].badv      = in_badv;
  end

`ifdef INST_QUEUE_BYPASS_EN
  assign byp = push && (count == '0);
`else
  assign byp = 1'b0;
`endif

  // In bypass, popped entries come straight from the packet and are never stored.
  assign wr_skip = byp ? pop_cnt : 2'd0;
  assign wr_n    = push ? (push_n - wr_skip) : 2'd0;
  assign st_pop  = byp ? 2'd0 : pop_cnt;
  assign avail   = byp ? CW'(push_n) : count;

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (wr_n != 2'd0) mem[tail] <= ent[wr_skip[0]];
      if (wr_n == 2'd2) mem[tail + ONE_P] <= ent[1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(st_pop);
      tail  <= tail + ptr_t'(wr_n);
      count <= count + CW'(wr_n) - CW'(st_pop);
    end
  end

  always @(posedge clk) begin
    if (rstn && !flush) begin
      assert (pop_cnt != 2'd3 && CW'(pop_cnt) <= avail);
    end
  end

  always_comb begin
    if (byp) begin
      slot[0] = ent[0];
      slot[1] = ent[1];
      valid   = (push_n == 2'd2) ? 2'b11 : 2'b01;
    end else begin
      slot[0] = mem[head];
      slot[1] = mem[head + ONE_P];
      valid   = {count >= TWO_C, count != '0};
    end
    for (int k = 0; k < 2; k++) begin
      if (!valid[k]) begin
        slot[k]      = '0;
        slot[k].inst = `INST_NOP;
      end
    end
  end

  assign out_valid      = valid;
  assign out_pc0        = slot[0].pc;
  assign out_pc1        = slot[1].pc;
  assign out_pc_next0   = slot[0].pc_next;
  assign out_pc_next1   = slot[1].pc_next;
  assign out_taken      = {slot[1].taken, slot[0].taken};
  assign out_inst0      = slot[0].inst;
  assign out_inst1      = slot[1].inst;
  assign out_excp       = {slot[1].excp, slot[0].excp};
  assign out_exception0 = slot[0].exception;
  assign out_exception1 = slot[1].exception;
  assign out_badv0      = slot[0].badv;
  assign out_badv1      = slot[1].badv;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8, SPACE_MARGIN=4); bypass checks follow INST_QUEUE_BYPASS_EN.
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module tb_inst_queue;
  localparam logic [31:0] MASK = 32'hAAAA0000;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready, in_taken;
  logic [31:0] in_pc, in_pc_next, in_inst0, in_inst1, in_badv;
  logic [1:0]  in_excp_flag, pop_cnt;
  logic [6:0]  in_exception;
  logic        space_ok, nearly_full;
  logic [1:0]  out_valid, out_taken, out_excp;
  logic [31:0] out_pc0, out_pc1, out_pc_next0, out_pc_next1;
  logic [31:0] out_inst0, out_inst1, out_badv0, out_badv1;
  logic [6:0]  out_exception0, out_exception1;

  int checks = 0;
  int errors = 0;

  inst_queue dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_next(in_pc_next), .in_taken(in_taken),
    .in_inst0(in_inst0), .in_inst1(in_inst1),
    .in_excp_flag(in_excp_flag), .in_exception(in_exception), .in_badv(in_badv),
    .space_ok(space_ok), .nearly_full(nearly_full), .out_valid(out_valid),
    .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_pc_next0(out_pc_next0), .out_pc_next1(out_pc_next1),
    .out_taken(out_taken), .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_excp(out_excp), .out_exception0(out_exception0), .out_exception1(out_exception1),
    .out_badv0(out_badv0), .out_badv1(out_badv1), .pop_cnt(pop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic rdy, input logic ok, input logic nf);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    chk({tag, "_space_ok"}, {31'd0, space_ok}, {31'd0, ok});
    chk({tag, "_nearly_full"}, {31'd0, nearly_full}, {31'd0, nf});
  endtask

  task automatic idle();
    in_valid = 1'b0;
    pop_cnt  = 2'd0;
    flush    = 1'b0;
  endtask

  task automatic set_pkt(input logic [31:0] pc, input logic [31:0] pcn, input logic tk,
                         input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] ef,
                         input logic [6:0] ex, input logic [31:0] bv);
    in_valid = 1'b1;  in_pc = pc;  in_pc_next = pcn;  in_taken = tk;
    in_inst0 = i0;  in_inst1 = i1;  in_excp_flag = ef;  in_exception = ex;  in_badv = bv;
  endtask

  // Sequential packet: instructions encode their own PC so data can be checked anywhere.
  task automatic seq_pkt(input logic [31:0] pc);
    logic [31:0] pcn;
    pcn = pc[2] ? pc + 32'd4 : pc + 32'd8;
    set_pkt(pc, pcn, 1'b0, pc ^ MASK, (pc + 32'd4) ^ MASK, 2'b00, 7'h00, 32'h0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    set_pkt(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00, 7'h00, 32'h0);
    in_valid = 1'b0;
    #12;
    chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
    chk("rst_out_inst0", out_inst0, `INST_NOP);
    chk("rst_out_pc0", out_pc0, 32'h0);
    chk_flags("rst", 1'b1, 1'b1, 1'b0);
    #10;
    rstn = 1'b1;

    // Two-entry packet
    set_pkt(32'h1C000000, 32'h1C000008, 1'b0, 32'h02800421, 32'h02800842, 2'b00, 7'h00, 32'h0);
    cycle();
    chk("p2_out_valid", {30'd0, out_valid}, 32'd3);
    chk("p2_out_pc0", out_pc0, 32'h1C000000);
    chk("p2_out_pc1", out_pc1, 32'h1C000004);
    chk("p2_out_pc_next0", out_pc_next0, 32'h1C000004);
    chk("p2_out_pc_next1", out_pc_next1, 32'h1C000008);
    chk("p2_out_inst0", out_inst0, 32'h02800421);
    chk("p2_out_inst1", out_inst1, 32'h02800842);
    chk("p2_out_taken", {30'd0, out_taken}, 32'd0);
    chk_flags("p2", 1'b1, 1'b1, 1'b0);

    // Single-entry packet (pc[2]=1), taken
    set_pkt(32'h1C000004, 32'h1C000100, 1'b1, 32'h02800c63, 32'hDEADBEEF, 2'b00, 7'h00, 32'h0);
    cycle();
    chk_flags("p1_c3", 1'b1, 1'b1, 1'b0);
    pop_cnt = 2'd2;
    cycle();
    chk("p1_out_valid", {30'd0, out_valid}, 32'd1);
    chk("p1_out_pc0", out_pc0, 32'h1C000004);
    chk("p1_out_pc_next0", out_pc_next0, 32'h1C000100);
    chk("p1_out_taken", {30'd0, out_taken}, 32'd1);
    chk("p1_out_inst0", out_inst0, 32'h02800c63);
    chk("p1_out_inst1", out_inst1, `INST_NOP);
    chk("p1_out_pc1", out_pc1, 32'h0);
    pop_cnt = 2'd1;
    cycle();
    chk("empty_out_valid", {30'd0, out_valid}, 32'd0);

    // Fill to count 7: 1 + 2 + 2 + 2 entries
    seq_pkt(32'h1C000204);
    cycle();
    chk_flags("fill_c1", 1'b1, 1'b1, 1'b0);
    seq_pkt(32'h1C000208);
    cycle();
    chk_flags("fill_c3", 1'b1, 1'b1, 1'b0);
    seq_pkt(32'h1C000210);
    cycle();
    chk_flags("fill_c5", 1'b1, 1'b0, 1'b1);
    seq_pkt(32'h1C000218);
    cycle();
    chk_flags("fill_c7", 1'b0, 1'b0, 1'b0);
    seq_pkt(32'h1C000220);
    cycle();
    chk_flags("blocked", 1'b0, 1'b0, 1'b0);
    chk("blocked_out_valid", {30'd0, out_valid}, 32'd3);
    chk("blocked_out_pc0", out_pc0, 32'h1C000204);
    chk("blocked_out_pc1", out_pc1, 32'h1C000208);
    chk("blocked_out_inst0", out_inst0, 32'h1C000204 ^ MASK);
    pop_cnt = 2'd1;
    cycle();
    chk_flags("c6", 1'b1, 1'b0, 1'b1);
    chk("c6_out_pc0", out_pc0, 32'h1C000208);

    // Steady state at count 6, push 2 / pop 2, pointers wrap
    for (int i = 0; i < 10; i++) begin
      seq_pkt(32'h1C000220 + 32'(8 * i));
      pop_cnt = 2'd2;
      #1;
      chk("ss_out_pc0", out_pc0, 32'h1C000208 + 32'(8 * i));
      chk("ss_out_pc1", out_pc1, 32'h1C00020C + 32'(8 * i));
      chk("ss_out_inst1", out_inst1, (32'h1C00020C + 32'(8 * i)) ^ MASK);
      @(posedge clk);
      #1;
    end
    idle();
    #1;
    chk("ss_end_out_valid", {30'd0, out_valid}, 32'd3);
    chk("ss_end_out_pc0", out_pc0, 32'h1C000258);
    chk_flags("ss_end", 1'b1, 1'b0, 1'b1);

    // Flush at count 5 wins over push and pop
    pop_cnt = 2'd1;
    cycle();
    chk_flags("c5", 1'b1, 1'b0, 1'b1);
    chk("c5_out_pc0", out_pc0, 32'h1C00025C);
    seq_pkt(32'h1C000270);
    pop_cnt = 2'd2;
    flush = 1'b1;
    cycle();
    chk("flush_out_valid", {30'd0, out_valid}, 32'd0);
    chk("flush_out_inst0", out_inst0, `INST_NOP);
    chk("flush_out_pc0", out_pc0, 32'h0);
    chk_flags("flush", 1'b1, 1'b1, 1'b0);

    // Exception fields copied to both entries
    set_pkt(32'h1C000040, 32'h1C000048, 1'b0, 32'h02800421, 32'h02800842, 2'b10, 7'h08, 32'h1C000044);
`ifdef INST_QUEUE_BYPASS_EN
    #1;
    chk("byp_out_valid", {30'd0, out_valid}, 32'd3);
    chk("byp_out_excp", {30'd0, out_excp}, 32'd2);
    chk("byp_out_exception0", {25'd0, out_exception0}, 32'h08);
    chk("byp_out_exception1", {25'd0, out_exception1}, 32'h08);
    chk("byp_out_badv0", out_badv0, 32'h1C000044);
    chk("byp_out_badv1", out_badv1, 32'h1C000044);
`endif
    cycle();
    chk("ex_out_valid", {30'd0, out_valid}, 32'd3);
    chk("ex_out_excp", {30'd0, out_excp}, 32'd2);
    chk("ex_out_exception0", {25'd0, out_exception0}, 32'h08);
    chk("ex_out_exception1", {25'd0, out_exception1}, 32'h08);
    chk("ex_out_badv0", out_badv0, 32'h1C000044);
    chk("ex_out_badv1", out_badv1, 32'h1C000044);
    chk("ex_out_pc1", out_pc1, 32'h1C000044);

    // Asynchronous reset mid-operation
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", {30'd0, out_valid}, 32'd0);
    chk("arst_out_inst1", out_inst1, `INST_NOP);
    chk_flags("arst", 1'b1, 1'b1, 1'b0);
    #2;
    rstn = 1'b1;
    @(negedge clk);

`ifdef INST_QUEUE_BYPASS_EN
    // Bypass with one entry consumed: only the second entry is stored
    seq_pkt(32'h1C000300);
    pop_cnt = 2'd1;
    #1;
    chk("byp_pop1_out_pc0", out_pc0, 32'h1C000300);
    chk("byp_pop1_out_valid", {30'd0, out_valid}, 32'd3);
    cycle();
    chk("byp_pop1_after_valid", {30'd0, out_valid}, 32'd1);
    chk("byp_pop1_after_pc0", out_pc0, 32'h1C000304);
    chk("byp_pop1_after_pc_next0", out_pc_next0, 32'h1C000308);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoupling instruction queue between the IF1 stage register and the decode stage.
- Accepts one fetch packet per cycle from IF1. A packet carries 1 or 2 instructions: slot1 is dropped when pc[2]=1.
- Splits each packet into per-instruction entries and presents up to two head entries to decode, which pops 0, 1 or 2 per cycle.
- Drives the IF1 back-pressure signals: in_ready (fifo_allowin), space_ok, nearly_full.

Parameters:
- DEPTH, 8: entries; power of two, >= 4.
- LOG_DEPTH, 3: log2(DEPTH).
- SPACE_MARGIN, 4: minimum free entries for space_ok; 2 < SPACE_MARGIN <= DEPTH.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- flush  in  1  synchronous clear of the queue
- in_valid  in  1  packet valid from IF1 (fifo_readygo)
- in_ready  out  1  queue accepts a packet (fifo_allowin)
- in_pc  in  32  packet PC
- in_pc_next  in  32  predicted next PC after the packet
- in_taken  in  1  packet predicted taken
- in_inst0  in  32  slot0 instruction
- in_inst1  in  32  slot1 instruction
- in_excp_flag  in  2  per-slot exception flag, bit0 = slot0
- in_exception  in  7  exception code, shared by the packet
- in_badv  in  32  bad virtual address, shared by the packet
- space_ok  out  1  free >= SPACE_MARGIN
- nearly_full  out  1  2 <= free < SPACE_MARGIN
- out_valid  out  2  bit k set when head+k is occupied
- out_pc0, out_pc1  out  32 each  entry PCs
- out_pc_next0, out_pc_next1  out  32 each  entry next PCs
- out_taken  out  2  per-entry taken
- out_inst0, out_inst1  out  32 each  entry instructions
- out_excp  out  2  per-entry exception flag
- out_exception0, out_exception1  out  7 each  per-entry exception code
- out_badv0, out_badv1  out  32 each  per-entry bad virtual address
- pop_cnt  in  2  entries consumed this cycle (0..2)

Behaviour:
- Reset (rstn=0, async): head=tail=count=0. Outputs: in_ready=1, space_ok=1, nearly_full=0, out_valid=0.
- Invalid out slots: when out_valid[k]=0, inst = `INST_NOP and all other fields of that slot = 0.
- Storage arrays are not reset.
- Packet split:
  - n = in_pc[2] ? 1 : 2.
  - Entry A: pc=in_pc, inst=in_inst0, excp=in_excp_flag[0].
  - Entry B (only if n=2): pc=in_pc+4, inst=in_inst1, excp=in_excp_flag[1].
  - The last entry of the packet carries pc_next=in_pc_next and taken=in_taken.
  - Any earlier entry carries pc_next=its pc+4 and taken=0.
  - in_exception and in_badv are copied into every entry of the packet.
- Push: occurs when in_valid && in_ready. Writes n entries at tail and tail+1 (mod DEPTH); tail += n.
- in_ready = (DEPTH - count) >= 2. It is computed from registered count only; there is no combinational path from pop_cnt.
- Pop: head += pop_cnt; entries leave at the clock edge. pop_cnt > count is illegal and must be asserted against in simulation.
- out_valid = {count>=2, count>=1}, taken from registered count.
- Outputs are a combinational read of head and head+1 (mod DEPTH). Write latency: 1 cycle from push to visibility.
- Simultaneous push and pop: count_next = count + push_n - pop_cnt.
  - A push to an almost-full queue is decided on the pre-pop count; free space released by a same-cycle pop is not used.
- Wrap-around: pointers are LOG_DEPTH bits and wrap naturally. A 2-entry push at tail=DEPTH-1 writes DEPTH-1 and 0.
- Flush: highest priority. head=tail=count=0 next cycle; any same-cycle push and pop are discarded. Reset mid-operation behaves identically, asynchronously.
- space_ok and nearly_full are derived from registered count:
  - full (free=0) and free=1 give space_ok=0, nearly_full=0, in_ready=0.
  - Empty gives space_ok=1, nearly_full=0.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined: when count=0 and in_valid && in_ready, the split packet entries are driven directly onto the out ports in the same cycle.
  - out_valid = n-bit mask.
  - Bypassed entries popped in that cycle are not written.
  - Entries left unpopped are written, with tail and count adjusted by n - pop_cnt.
  - pop_cnt > n is illegal.
- Undefined: no bypass; minimum push-to-decode latency is 1 cycle.

Test Plan:
- Reset, then push pc=0x1C000000, inst0=0x02800421, inst1=0x02800842, pc_next=0x1C000008, pop_cnt=0.
  -> Next cycle out_valid=2'b11, out_pc1=0x1C000004, out_pc_next0=0x1C000004, out_pc_next1=0x1C000008, count=2.
- Push pc=0x1C000004 (pc[2]=1), in_taken=1, pc_next=0x1C000100.
  -> Exactly one entry written: pc=0x1C000004, taken=1, pc_next=0x1C000100.
- Push 2-entry packets with pop_cnt=0 until full (DEPTH=8).
  -> in_ready drops at count=7.
  -> space_ok=0 from count=5.
  -> nearly_full=1 at count 5..6.
  -> No overwrite after full; head data unchanged.
- Steady state, count=6: push 2 and pop 2 each cycle for 10 cycles with pointers crossing index 7->0.
  -> count stays 6; output PCs strictly sequential by +4.
- count=5: flush=1 together with in_valid=1 and pop_cnt=2.
  -> Next cycle count=0, out_valid=0, out_inst0=`INST_NOP, in_ready=1.
- in_excp_flag=2'b10, in_exception=7'h08, in_badv=0x1C000044, pc=0x1C000040.
  -> out_excp=2'b10, both entries exception=7'h08, badv=0x1C000044.
  -> With INST_QUEUE_BYPASS_EN on an empty queue, these values appear in the same cycle.
